// File: rtl/cgra_pkg.sv
// Shared types and default sizes for the tile datapath blocks.
package cgra_pkg;

  localparam int WIDTH      = 16;
  localparam int NUM_INPUTS = 4;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } coll_state_t;

endpackage : cgra_pkg

// File: rtl/tile_input_collector_if.sv
// Neighbour-link inputs and regfile write-port signals of the input collector.
interface tile_input_collector_if #(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int CNT_W      = 16
);

  logic [NUM_INPUTS-1:0][WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_vld;
  logic [NUM_INPUTS-1:0]            in_rdy;
  logic [NUM_INPUTS-1:0]            in_mask;
  logic                             wen;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] w_data;
  logic                             wr_ack;
  logic                             busy;
  logic [CNT_W-1:0]                 fire_count;

  // Environment side: neighbours, configuration and the register file.
  modport master (
    output in_data, in_vld, in_mask, wr_ack,
    input  in_rdy, wen, w_data, busy, fire_count
  );

  // Collector side.
  modport slave (
    input  in_data, in_vld, in_mask, wr_ack,
    output in_rdy, wen, w_data, busy, fire_count
  );

endinterface : tile_input_collector_if

// File: rtl/tile_input_collector_lane_fifo.sv
// Per-lane token FIFO. Ready depends on the registered count only, so a full
// FIFO refuses a push even when it is being popped in the same cycle.
module lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1'b1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1'b1);
        2'b01:   count_q <= count_q - CW'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Token storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= din;
  end

endmodule : lane_fifo

// File: rtl/tile_input_collector.sv
// Collects one token per selected lane and issues them as a single bundled
// write to regfile port 1, holding the bundle until it is acknowledged.
module tile_input_collector
  import cgra_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_INPUTS = 4,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  tile_input_collector_if.slave  bus
);

  coll_state_t                      state_q, state_d;
  logic [NUM_INPUTS-1:0]            mask_q, mask_d;
  logic                             wen_q, wen_d;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic [NUM_INPUTS-1:0][WIDTH-1:0] head_s;
  logic [NUM_INPUTS-1:0]            full_s;
  logic [NUM_INPUTS-1:0]            empty_s;
  logic [NUM_INPUTS-1:0]            pop_s;
  logic                             fire_ok_s;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.in_vld[g]),
      .din   (bus.in_data[g]),
      .pop   (pop_s[g]),
      .dout  (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
  end

  // A firing needs a non-empty mask whose lanes all hold a token.
  assign fire_ok_s = (bus.in_mask != {NUM_INPUTS{1'b0}}) &&
                     ((bus.in_mask & empty_s) == {NUM_INPUTS{1'b0}});
  // Consumed tokens leave on the same edge that samples the acknowledge.
  assign pop_s = ((state_q == WRITE) && bus.wr_ack) ? mask_q : {NUM_INPUTS{1'b0}};

  assign bus.in_rdy     = ~full_s;
  assign bus.wen        = wen_q;
  assign bus.w_data     = wdata_q;
  assign bus.busy       = (state_q == WRITE);
  assign bus.fire_count = cnt_q;

  // Next-state logic: latch a bundle in IDLE, release it on acknowledge.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fire_ok_s) begin
          state_d = WRITE;
          mask_d  = bus.in_mask;
          wen_d   = 1'b1;
          for (int i = 0; i < NUM_INPUTS; i++) begin
            wdata_d[i] = bus.in_mask[i] ? head_s[i] : {WIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (bus.wr_ack) begin
          state_d = IDLE;
          wen_d   = 1'b0;
          wdata_d = {(NUM_INPUTS*WIDTH){1'b0}};
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1'b1);
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
        wen_d   = 1'b0;
        wdata_d = {(NUM_INPUTS*WIDTH){1'b0}};
      end
    endcase
  end

  // State, bundle and firing-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= {NUM_INPUTS{1'b0}};
      wen_q   <= 1'b0;
      wdata_q <= {(NUM_INPUTS*WIDTH){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : tile_input_collector

// File: tb/tb_tile_input_collector.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-based reference model of the collector.
module tb_tile_input_collector;
  import cgra_pkg::*;

  localparam int W  = 16;
  localparam int NI = 4;
  localparam int D  = 2;
  localparam int CW = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  tile_input_collector_if #(.WIDTH(W), .NUM_INPUTS(NI), .CNT_W(CW)) bus ();

  tile_input_collector #(.WIDTH(W), .NUM_INPUTS(NI), .DEPTH(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  word_t     mq [NI][$];
  bit        m_busy;
  bit        m_wen;
  word_t     m_wdata [NI];
  bit [NI-1:0] m_mask;
  int        m_cnt;

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      m_wdata[i] = '0;
    end
    m_busy = 1'b0;
    m_wen  = 1'b0;
    m_mask = '0;
    m_cnt  = 0;
  endtask

  // Apply the collector's rules for one clock edge using the current inputs.
  task automatic model_edge();
    bit [NI-1:0] acc;
    bit          ok;
    for (int i = 0; i < NI; i++) acc[i] = bus.in_vld[i] && (mq[i].size() < D);
    if (!m_busy) begin
      ok = (bus.in_mask != 0);
      for (int i = 0; i < NI; i++) if (bus.in_mask[i] && mq[i].size() == 0) ok = 1'b0;
      if (ok) begin
        m_busy = 1'b1;
        m_wen  = 1'b1;
        m_mask = bus.in_mask;
        for (int i = 0; i < NI; i++) m_wdata[i] = bus.in_mask[i] ? mq[i][0] : 16'h0000;
      end
    end else if (bus.wr_ack) begin
      for (int i = 0; i < NI; i++) if (m_mask[i]) void'(mq[i].pop_front());
      m_cnt  = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      m_busy = 1'b0;
      m_wen  = 1'b0;
      for (int i = 0; i < NI; i++) m_wdata[i] = 16'h0000;
    end
    for (int i = 0; i < NI; i++) if (acc[i]) mq[i].push_back(bus.in_data[i]);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NI-1:0]   e_rdy;
    logic [NI*W-1:0] e_wd;
    for (int i = 0; i < NI; i++) begin
      e_rdy[i]       = (mq[i].size() < D);
      e_wd[i*W +: W] = m_wdata[i];
    end
    chk({tag, "_rdy"},  64'(bus.in_rdy),     64'(e_rdy));
    chk({tag, "_wen"},  64'(bus.wen),        64'(m_wen));
    chk({tag, "_busy"}, 64'(bus.busy),       64'(m_busy));
    chk({tag, "_cnt"},  64'(bus.fire_count), 64'(m_cnt));
    chk({tag, "_wd"},   64'(bus.w_data),     64'(e_wd));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    model_clear();
    #1;
    chk("arst_wen", 64'(bus.wen), 64'd0);
    chk("arst_wd",  64'(bus.w_data), 64'd0);
    chk("arst_cnt", 64'(bus.fire_count), 64'd0);
    @(posedge clk);
    #1 check_all("in_rst");
    #2 reset = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.in_vld  = '0;
    bus.in_data = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.in_vld  = '0;
    bus.in_data = '0;
    bus.in_mask = '0;
    bus.wr_ack  = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    #2 reset = 1'b1;

    // Full-mask firing with ack tied high
    bus.in_mask = 4'b1111;
    bus.wr_ack  = 1'b1;
    bus.in_vld  = 4'b1111;
    bus.in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step("t1_acc");
    idle_inputs();
    step("t1_fire");
    chk("t1_wen", 64'(bus.wen), 64'd1);
    chk("t1_wd", 64'(bus.w_data), 64'h4444_3333_2222_1111);
    step("t1_ack");
    chk("t1_wen_low", 64'(bus.wen), 64'd0);
    chk("t1_cnt", 64'(bus.fire_count), 64'd1);

    // Partial mask leaves the unmasked lane untouched
    apply_reset();
    bus.in_mask = 4'b0101;
    bus.in_vld  = 4'b0111;
    bus.in_data = {16'h0000, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    step("t2_acc");
    idle_inputs();
    step("t2_fire");
    chk("t2_wd", 64'(bus.w_data), 64'h0000_CCCC_0000_AAAA);
    step("t2_ack");
    chk("t2_cnt", 64'(bus.fire_count), 64'd1);
    bus.in_mask = 4'b0010;
    step("t2_lane1");
    chk("t2_lane1_wd", 64'(bus.w_data), 64'h0000_0000_BBBB_0000);
    step("t2_lane1_ack");

    // Withheld acknowledge: bundle held stable, one pop on ack
    bus.wr_ack  = 1'b0;
    bus.in_mask = 4'b0011;
    bus.in_vld  = 4'b0011;
    bus.in_data = {16'h0000, 16'h0000, 16'h5A5A, 16'hA5A5};
    step("t3_acc");
    idle_inputs();
    step("t3_fire");
    for (int k = 0; k < 5; k++) begin
      step("t3_hold");
      chk("t3_hold_wd", 64'(bus.w_data), 64'h0000_0000_5A5A_A5A5);
      chk("t3_hold_busy", 64'(bus.busy), 64'd1);
    end
    bus.wr_ack = 1'b1;
    step("t3_ack");
    chk("t3_cnt", 64'(bus.fire_count), 64'd3);
    step("t3_after");
    chk("t3_no_refire", 64'(bus.wen), 64'd0);

    // Backpressure on a full lane, recovered by a firing
    apply_reset();
    bus.in_mask = 4'b0000;
    bus.in_vld  = 4'b0001;
    bus.in_data = {16'h0, 16'h0, 16'h0, 16'h0001};
    step("t4_p1");
    bus.in_data = {16'h0, 16'h0, 16'h0, 16'h0002};
    step("t4_p2");
    chk("t4_full", 64'(bus.in_rdy[0]), 64'd0);
    bus.in_data = {16'h0, 16'h0, 16'h0, 16'h0003};
    step("t4_stall");
    chk("t4_still_full", 64'(bus.in_rdy[0]), 64'd0);
    bus.in_mask = 4'b0001;
    step("t4_fire");
    chk("t4_wd", 64'(bus.w_data), 64'h0001);
    step("t4_pop");
    chk("t4_rdy_back", 64'(bus.in_rdy[0]), 64'd1);
    step("t4_acc3");
    idle_inputs();
    repeat (5) step("t4_drain");
    bus.in_mask = 4'b0000;

    // Reset in the middle of a bundle
    bus.wr_ack  = 1'b0;
    bus.in_mask = 4'b0011;
    bus.in_vld  = 4'b0111;
    bus.in_data = {16'h0, 16'h7777, 16'h6666, 16'h5555};
    step("t5_acc");
    idle_inputs();
    step("t5_fire");
    chk("t5_in_write", 64'(bus.wen), 64'd1);
    apply_reset();
    bus.wr_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("t5_post");
      chk("t5_rdy", 64'(bus.in_rdy), 64'hF);
      chk("t5_no_stale", 64'(bus.wen), 64'd0);
    end

    // Saturating counter
    apply_reset();
    bus.in_mask = 4'b0001;
    bus.wr_ack  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_vld  = 4'b0001;
      bus.in_data = {16'h0, 16'h0, 16'h0, 16'(k + 16'h0100)};
      step("t6_acc");
      idle_inputs();
      step("t6_fire");
      step("t6_ack");
      chk("t6_cnt", 64'(bus.fire_count), 64'((k + 1 > 3) ? 3 : k + 1));
    end

    // Random traffic against the reference model
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      bus.in_vld = 4'($urandom);
      for (int i = 0; i < NI; i++) bus.in_data[i] = 16'($urandom);
      bus.in_mask = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      bus.wr_ack  = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tile_input_collector
